// File: rtl/speccy_kbd_pkg.sv
// Shared types, matrix dimensions and PS/2 set-2 keymap for the
// Spectrum keyboard matrix to scancode bridge.
package speccy_kbd_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int NKEYS = ROWS * COLS;

  typedef enum logic [1:0] {
    DRIVE,
    SAMPLE,
    EMIT,
    NEXTROW
  } state_t;

  // {extended, code[7:0]}, indexed row * COLS + col
  localparam logic [8:0] KEYMAP [NKEYS] = '{
    9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A,
    9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034,
    9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
    9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E,
    9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036,
    9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035,
    9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033,
    9'h029, 9'h114, 9'h03A, 9'h031, 9'h032
  };

  // {extended, scan[6:0]} for one matrix position
  function automatic logic [7:0] key_entry(
    input logic [5:0] idx
  );
    return {KEYMAP[idx][8], KEYMAP[idx][6:0]};
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous key-event FIFO with full/empty flags.
// Push and pop in the same clock both take effect.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr;
  logic [AW:0]      rd;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr == rd);
  assign full    = (wr[AW] != rd[AW]) &&
                   (wr[AW-1:0] == rd[AW-1:0]);
  assign dout    = mem[rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (do_push) wr <= wr + (AW+1)'(1);
      if (do_pop)  rd <= rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/speccy_to_scancode.sv
// Scans a ZX Spectrum key matrix and emits PS/2 set-2 make/break events.
// Define SPECCY_TO_SCANCODE_DEBOUNCE_EN for per-key scan debouncing.
import speccy_kbd_pkg::*;

module speccy_to_scancode #(
  parameter int ROW_DWELL  = 256,
  parameter int EVT_GAP    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DEB_SCANS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] sp_row,
  input  logic [4:0] sp_col,
  output logic       scan_received,
  output logic [6:0] scan,
  output logic       extended,
  output logic       released,
  output logic       any_pressed
);

  localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
  localparam int GW = (EVT_GAP > 1) ? $clog2(EVT_GAP) : 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (DEB_SCANS < 1 || DEB_SCANS > 3) begin : g_bad_deb
    $error("DEB_SCANS must be 1..3");
  end
  if (EVT_GAP < 1 || ROW_DWELL < 1) begin : g_bad_time
    $error("EVT_GAP and ROW_DWELL must be >= 1");
  end

  state_t           state;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [DW-1:0]    dwell;
  logic [COLS-1:0]  col_q;
  logic [NKEYS-1:0] acc;
  logic [GW-1:0]    gap;
  logic [5:0]       key;
  logic             mismatch;
  logic             change;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [8:0]       head;

  assign key      = 6'(row) * 6'(COLS) + 6'(col);
  assign mismatch = (state == EMIT) && (~col_q[col] != acc[key]);
  assign push     = change && !full;
  assign pop      = !empty && (gap == '0);

`ifdef SPECCY_TO_SCANCODE_DEBOUNCE_EN
  logic [NKEYS-1:0][1:0] deb;

  assign change = mismatch && (deb[key] == 2'(DEB_SCANS - 1));

  // A blocked push keeps the count saturated so the next scan retries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
    end else if (state == EMIT) begin
      if (!mismatch || push) deb[key] <= '0;
      else if (!change)      deb[key] <= deb[key] + 2'd1;
    end
  end
`else
  assign change = mismatch;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DRIVE;
      row         <= '0;
      col         <= '0;
      dwell       <= '0;
      col_q       <= '1;
      acc         <= '0;
      sp_row      <= 8'hFF;
      any_pressed <= 1'b0;
    end else begin
      any_pressed <= |acc;
      unique case (state)
        DRIVE: begin
          sp_row <= ~(8'd1 << row);
          if (dwell == DW'(ROW_DWELL - 1)) begin
            dwell <= '0;
            state <= SAMPLE;
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        SAMPLE: begin
          col_q <= sp_col;
          col   <= '0;
          state <= EMIT;
        end
        EMIT: begin
          if (push) acc[key] <= ~acc[key];
          if (col == 3'(COLS - 1)) state <= NEXTROW;
          else                     col   <= col + 3'd1;
        end
        NEXTROW: begin
          row    <= row + 3'd1;
          sp_row <= ~(8'd1 << (row + 3'd1));
          state  <= DRIVE;
        end
        default: state <= DRIVE;
      endcase
    end
  end

  // Entry is {extended, scan, released}; released is the old state.
  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({key_entry(key), acc[key]}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_received <= 1'b0;
      scan          <= '0;
      extended      <= 1'b0;
      released      <= 1'b0;
      gap           <= '0;
    end else begin
      scan_received <= pop;
      if (pop) begin
        {extended, scan, released} <= head;
        gap <= GW'(EVT_GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
    end
  end

endmodule

// File: tb/tb_speccy_to_scancode.sv
// Randomised bench for speccy_to_scancode against a key-change model.
// Works with or without SPECCY_TO_SCANCODE_DEBOUNCE_EN defined.
module tb_speccy_to_scancode;

  localparam int DWELL = 4;
  localparam int GAP   = 4;
  localparam int GAP1  = 64;
  localparam int SCAN  = 8 * (DWELL + 7);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  row0, row1;
  logic [4:0]  col0, col1;
  logic        rcv0, rcv1, ext0, ext1;
  logic        rel0, rel1, any0, any1;
  logic [6:0]  sc0, sc1;
  logic [39:0] keys0, keys1, model;

  logic [6:0] code [40] = '{
    7'h12, 7'h1A, 7'h22, 7'h21, 7'h2A,
    7'h1C, 7'h1B, 7'h23, 7'h2B, 7'h34,
    7'h15, 7'h1D, 7'h24, 7'h2D, 7'h2C,
    7'h16, 7'h1E, 7'h26, 7'h25, 7'h2E,
    7'h45, 7'h46, 7'h3E, 7'h3D, 7'h36,
    7'h4D, 7'h44, 7'h43, 7'h3C, 7'h35,
    7'h5A, 7'h4B, 7'h42, 7'h3B, 7'h33,
    7'h29, 7'h14, 7'h3A, 7'h31, 7'h32
  };

  speccy_to_scancode #(
    .ROW_DWELL(DWELL), .EVT_GAP(GAP),
    .FIFO_DEPTH(8), .DEB_SCANS(3)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .sp_row(row0), .sp_col(col0),
    .scan_received(rcv0), .scan(sc0),
    .extended(ext0), .released(rel0),
    .any_pressed(any0)
  );

  speccy_to_scancode #(
    .ROW_DWELL(DWELL), .EVT_GAP(GAP1),
    .FIFO_DEPTH(64), .DEB_SCANS(3)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .sp_row(row1), .sp_col(col1),
    .scan_received(rcv1), .scan(sc1),
    .extended(ext1), .released(rel1),
    .any_pressed(any1)
  );

  always_comb begin
    col0 = '1;
    col1 = '1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) begin
        if (!row0[r] && keys0[r*5+c]) col0[c] = 1'b0;
        if (!row1[r] && keys1[r*5+c]) col1[c] = 1'b0;
      end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ev(input int k, input logic rel);
    return {k == 36, code[k], rel};
  endfunction

  logic [8:0] evq[$];
  logic [8:0] evq1[$];
  logic [8:0] expq[$];
  int cyc = 0, last0 = 0, last1 = 0;
  int min_gap1 = 1000000;
  bit have0 = 0, have1 = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      have0 = 0;
      have1 = 0;
    end
    if (rcv0) begin
      if (have0) check("gap", 32'((cyc - last0) >= GAP), 1);
      last0 = cyc;
      have0 = 1;
      evq.push_back({ext0, sc0, rel0});
    end
    if (rcv1) begin
      if (have1 && (cyc - last1) < min_gap1) min_gap1 = cyc - last1;
      last1 = cyc;
      have1 = 1;
      evq1.push_back({ext1, sc1, rel1});
    end
  end

  task automatic sync0();
    int n = 0;
    while (row0 == 8'hFE && n < 200) begin
      @(negedge clk); n++;
    end
    while (row0 != 8'hFE && n < 400) begin
      @(negedge clk); n++;
    end
    check("sync_row0", row0, 8'hFE);
  endtask

  task automatic wait_cmp(input bit ordered);
    int n = 0;
    bit hit;
    while (evq.size() < expq.size() && n < 8000) begin
      @(negedge clk); n++;
    end
    repeat (3 * SCAN) @(negedge clk);
    check("evt_count", evq.size(), expq.size());
    if (ordered) begin
      for (int i = 0; i < evq.size() && i < expq.size(); i++)
        check("evt_order", evq[i], expq[i]);
    end else begin
      foreach (evq[i]) begin
        hit = 0;
        for (int j = 0; j < expq.size(); j++)
          if (!hit && expq[j] == evq[i]) begin
            expq.delete(j);
            hit = 1;
          end
        check("evt_match", hit, 1);
      end
    end
    evq.delete();
  endtask

  task automatic apply(input logic [39:0] nk, input bit ordered);
    sync0();
    expq.delete();
    for (int k = 0; k < 40; k++)
      if (nk[k] != model[k]) expq.push_back(ev(k, model[k]));
    keys0 = nk;
    model = nk;
    wait_cmp(ordered);
    check("any_pressed", any0, 32'(|model));
  endtask

  logic [39:0] nk;
  int n, j, strobes;

  initial begin
    rst_n = 1'b0;
    keys0 = '0;
    keys1 = '1;
    model = '0;
    repeat (3) @(negedge clk);
    check("rst_row", row0, 8'hFF);
    check("rst_rcv", rcv0, 0);
    check("rst_scan", sc0, 0);
    check("rst_ext", ext0, 0);
    check("rst_rel", rel0, 0);
    check("rst_any", any0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("row_start", row0, 8'hFE);

    n = 0;
    while (evq1.size() < 40 && n < 8000) begin
      @(negedge clk); n++;
    end
    repeat (200) @(negedge clk);
    check("all40_count", evq1.size(), 40);
    for (int i = 0; i < 40 && i < evq1.size(); i++)
      check($sformatf("all40_%0d", i), evq1[i], ev(i, 1'b0));
    check("all40_gap", 32'(min_gap1 >= GAP1), 1);
    check("all40_any", any1, 1);

    apply(40'd1 << 1, 1);
    apply(40'd0, 1);
    apply(40'd1 << 36, 1);
    apply(40'd0, 1);

    sync0();
    keys0[1] = 1'b1;
    sync0();
    keys0[1] = 1'b0;
    expq.delete();
`ifndef SPECCY_TO_SCANCODE_DEBOUNCE_EN
    expq.push_back(ev(1, 1'b0));
    expq.push_back(ev(1, 1'b1));
`endif
    wait_cmp(1);

    apply(40'h1F << 5, 1);
    apply(40'd0, 1);

    repeat (6) begin
      nk = model;
      repeat ($urandom_range(1, 8)) begin
        j = $urandom_range(0, 39);
        nk[j] = ~nk[j];
      end
      apply(nk, 1);
    end
    apply(40'({$urandom(), $urandom()}), 0);
    apply(40'd0, 0);

    sync0();
    keys0 = 40'h1F << 10;
    n = 0;
    while (row0 != 8'hFB && n < 200) begin
      @(negedge clk); n++;
    end
    check("reach_row2", row0, 8'hFB);
    repeat (DWELL + 4) @(negedge clk);
    rst_n = 1'b0;
    evq.delete();
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      if (rcv0) strobes++;
    end
    check("midrst_row", row0, 8'hFF);
    check("midrst_any", any0, 0);
    check("midrst_strobes", strobes, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rcv", rcv0, 0);
    check("post_rst_row", row0, 8'hFE);
    expq.delete();
    for (int k = 10; k < 15; k++) expq.push_back(ev(k, 1'b0));
    model = keys0;
    wait_cmp(1);
    apply(40'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
